uart_byte_fifo: RTL and testbench

Byte FIFO placed between the UART receive path and the UART transmit path. Words strobed in by the receiver are buffered. They are presented to the transmitter with a valid/ready handshake. This keeps received bytes from being lost while the transmitter is busy. Occupancy and a sticky overflow flag are exported for the board LEDs.

---
 rtl/uart_byte_fifo.sv | 62 ++++++
 tb/tb_uart_byte_fifo.sv | 130 +++++++++++++
 2 files changed

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: first-word-fall-through byte FIFO between UART rx and tx; define UART_FIFO_LINE_EN to release words only as whole lines
module uart_byte_fifo #(
  parameter int BW = 9,
  parameter int LGDEPTH = 4
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_wr_stb,
  input  logic [BW-1:0]      i_wr_data,
  output logic               o_rd_valid,
  output logic [BW-1:0]      o_rd_data,
  input  logic               i_rd_ready,
  output logic               o_full,
  output logic               o_empty,
  output logic [LGDEPTH:0]   o_count,
  output logic               o_overflow,
  input  logic               i_clr_overflow
);
  localparam int DEPTH = 2**LGDEPTH;
  logic [BW-1:0] mem [DEPTH];
  logic [LGDEPTH-1:0] wr_ptr, rd_ptr;
  logic [LGDEPTH:0] count;
  logic push, pop, drop;
  assign o_count = count;
  assign o_full = count == (LGDEPTH+1)'(DEPTH);
  assign o_empty = count == '0;
  assign o_rd_data = mem[rd_ptr];
  assign pop = o_rd_valid && i_rd_ready;
  assign push = i_wr_stb && (!o_full || pop);
  assign drop = i_wr_stb && !push;
`ifdef UART_FIFO_LINE_EN
  logic [LGDEPTH:0] newlines;
  logic nl_in, nl_out;
  assign nl_in = push && i_wr_data[7:0] == 8'h0A;
  assign nl_out = pop && o_rd_data[7:0] == 8'h0A;
  assign o_rd_valid = newlines != '0 || o_full;
  // newline occupancy: lets the transmitter drain only complete lines
  always_ff @(posedge clk or posedge i_reset)
    if (i_reset) newlines <= '0;
    else newlines <= nl_in && !nl_out ? newlines + (LGDEPTH+1)'(1) :
                     nl_out && !nl_in ? newlines - (LGDEPTH+1)'(1) : newlines;
`else
  assign o_rd_valid = !o_empty;
`endif
  // storage array, deliberately left unreset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= i_wr_data;
  // pointers, occupancy and sticky overflow; a drop beats a same-cycle clear
  always_ff @(posedge clk or posedge i_reset)
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      o_overflow <= 1'b0;
    end else begin
      wr_ptr <= push ? wr_ptr + LGDEPTH'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + LGDEPTH'(1) : rd_ptr;
      count <= push && !pop ? count + (LGDEPTH+1)'(1) :
               pop && !push ? count - (LGDEPTH+1)'(1) : count;
      o_overflow <= drop ? 1'b1 : i_clr_overflow ? 1'b0 : o_overflow;
    end
endmodule

// File: tb/tb_uart_byte_fifo.sv
// tb_uart_byte_fifo: directed and random stimulus checked against a queue-based model of uart_byte_fifo
module tb_uart_byte_fifo;
  localparam int BW = 9;
  localparam int LGDEPTH = 4;
  localparam int DEPTH = 16;
`ifdef UART_FIFO_LINE_EN
  localparam bit LINE = 1'b1;
`else
  localparam bit LINE = 1'b0;
`endif
  logic clk = 0, i_reset = 1, i_wr_stb = 0, i_rd_ready = 0, i_clr_overflow = 0;
  logic [BW-1:0] i_wr_data = '0;
  logic o_rd_valid, o_full, o_empty, o_overflow;
  logic [BW-1:0] o_rd_data;
  logic [LGDEPTH:0] o_count;
  int vectors = 0, miscompares = 0;
  logic [BW-1:0] q[$];
  logic ov = 0;

  uart_byte_fifo #(.BW(BW), .LGDEPTH(LGDEPTH)) dut (
    .clk(clk), .i_reset(i_reset), .i_wr_stb(i_wr_stb), .i_wr_data(i_wr_data),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .o_overflow(o_overflow), .i_clr_overflow(i_clr_overflow)
  );

  always #5 clk = ~clk;

  function automatic int newline_words();
    int n = 0;
    foreach (q[i]) if (q[i][7:0] == 8'h0A) n++;
    return n;
  endfunction

  function automatic bit model_valid();
    return LINE ? (newline_words() > 0 || q.size() == DEPTH) : q.size() > 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(o_count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(o_empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(o_full), 32'(q.size() == DEPTH));
    chk({tag, ".valid"}, 32'(o_rd_valid), 32'(model_valid()));
    chk({tag, ".overflow"}, 32'(o_overflow), 32'(ov));
    if (model_valid()) chk({tag, ".data"}, 32'(o_rd_data), 32'(q[0]));
  endtask

  task automatic step(input string tag, input bit wr, input logic [BW-1:0] d, input bit rdy, input bit clr);
    bit pop, acc;
    i_wr_stb = wr;
    i_wr_data = d;
    i_rd_ready = rdy;
    i_clr_overflow = clr;
    pop = model_valid() && rdy;
    acc = wr && (q.size() < DEPTH || pop);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(d);
    ov = (wr && !acc) ? 1'b1 : clr ? 1'b0 : ov;
    @(negedge clk);
    i_wr_stb = 0;
    i_rd_ready = 0;
    i_clr_overflow = 0;
    check_all(tag);
  endtask

  task automatic pulse_reset();
    i_reset = 1;
    @(posedge clk);
    @(negedge clk);
    i_reset = 0;
    q.delete();
    ov = 0;
    check_all("reset");
  endtask

  initial begin
    @(posedge clk);
    @(negedge clk);
    i_reset = 0;
    check_all("reset");
    step("single_wr", 1, 9'h041, 0, 0);
    chk("single_wr.data41", 32'(o_rd_data), 32'h041);
    step("single_pop", 0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) step("fill", 1, BW'(i), 0, 0);
    step("overflow", 1, 9'h055, 0, 0);
    chk("overflow.sticky", 32'(o_overflow), 32'd1);
    step("clr_and_drop", 1, 9'h056, 0, 1);
    step("clr", 0, 0, 0, 1);
    step("full_rw", 1, 9'h077, 1, 0);
    for (int i = 0; i < DEPTH; i++) step("drain", 0, 0, 1, 0);
    pulse_reset();
    step("wrap_pre", 1, BW'($urandom_range(0, 511)), 0, 0);
    step("wrap_pre", 1, BW'($urandom_range(0, 511)), 0, 0);
    for (int i = 0; i < 40; i++) step("wrap", 1, BW'($urandom_range(0, 511)), 1, 0);
    pulse_reset();
    for (int i = 0; i < 5; i++) step("pre_async", 1, BW'($urandom_range(0, 511)), 0, 0);
    @(posedge clk);
    #1 i_reset = 1;
    q.delete();
    ov = 0;
    #1 check_all("async_reset");
    @(negedge clk);
    i_reset = 0;
    check_all("after_async");
    for (int i = 0; i < 300; i++)
      step("random", bit'($urandom_range(0, 3) != 0), BW'($urandom_range(0, 15) == 0 ? 10 : $urandom_range(0, 511)),
           bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 15) == 0));
`ifdef UART_FIFO_LINE_EN
    pulse_reset();
    step("line_h", 1, 9'h068, 1, 0);
    step("line_i", 1, 9'h069, 1, 0);
    chk("line.hold", 32'(o_rd_valid), 32'd0);
    step("line_nl", 1, 9'h00A, 0, 0);
    chk("line.release", 32'(o_rd_valid), 32'd1);
    for (int i = 0; i < 3; i++) step("line_drain", 0, 0, 1, 0);
    chk("line.drop", 32'(o_rd_valid), 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
